// File: rtl/rv32_alu_issue_stage_pkg.sv
// Shared ALU control codes, RV32I opcodes and the decoded-entry record used by
// the issue stage and its decoder.
package rv32_alu_issue_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } decoded_t;

  function automatic logic [3:0] funct3_to_ctrl(input logic [2:0] funct3);
    logic [3:0] ctrl;
    case (funct3)
      3'b000:  ctrl = ALU_ADD;
      3'b001:  ctrl = ALU_SLL;
      3'b010:  ctrl = ALU_SLT;
      3'b011:  ctrl = ALU_SLTU;
      3'b100:  ctrl = ALU_XOR;
      3'b101:  ctrl = ALU_SRL;
      3'b110:  ctrl = ALU_OR;
      3'b111:  ctrl = ALU_AND;
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/rv32_alu_decoder.sv
// Combinational RV32I OP / OP-IMM / LUI / AUIPC decoder producing the ALU
// control code, operand selects, extended immediate and register indices.
module rv32_alu_decoder
  import rv32_alu_issue_stage_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0] opcode_s;
  logic [6:0] funct7_s;
  logic [2:0] funct3_s;
  logic       illegal_s;

  assign opcode_s = instr[6:0];
  assign funct7_s = instr[31:25];
  assign funct3_s = instr[14:12];

  // Field extraction, operation selection and legality checking
  always_comb begin
    dec       = '0;
    illegal_s = 1'b0;
    dec.rs1   = instr[19:15];
    dec.rs2   = instr[24:20];
    dec.rd    = instr[11:7];
    case (opcode_s)
      OPC_OP: begin
        if (funct7_s == F7_ZERO) begin
          dec.alu_ctrl = funct3_to_ctrl(funct3_s);
        end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b000)) begin
          dec.alu_ctrl = ALU_SUB;
        end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
          dec.alu_ctrl = ALU_SRA;
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.use_imm  = 1'b1;
        dec.alu_ctrl = funct3_to_ctrl(funct3_s);
        dec.imm      = {{20{instr[31]}}, instr[31:20]};
        // Shift-immediates carry only the 5-bit shamt; upper bits select the shift kind
        if (funct3_s == 3'b001) begin
          dec.imm   = {27'd0, instr[24:20]};
          illegal_s = (funct7_s != F7_ZERO);
        end else if (funct3_s == 3'b101) begin
          dec.imm = {27'd0, instr[24:20]};
          if (funct7_s == F7_ALT) begin
            dec.alu_ctrl = ALU_SRA;
          end else begin
            illegal_s = (funct7_s != F7_ZERO);
          end
        end else begin
          illegal_s = 1'b0;
        end
      end
      OPC_LUI: begin
        dec.rs1     = 5'd0;
        dec.imm     = {instr[31:12], 12'd0};
        dec.use_imm = 1'b1;
      end
      OPC_AUIPC: begin
        dec.rs1     = 5'd0;
        dec.imm     = {instr[31:12], 12'd0};
        dec.use_imm = 1'b1;
        dec.use_pc  = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase

    if (illegal_s) begin
      dec.alu_ctrl = ALU_ADD;
      dec.use_imm  = 1'b0;
      dec.use_pc   = 1'b0;
    end else begin
      dec.alu_ctrl = dec.alu_ctrl;
    end
    dec.illegal   = illegal_s;
    dec.reg_write = !illegal_s && (dec.rd != 5'd0);
  end

endmodule

// File: rtl/rv32_alu_issue_stage.sv
// ALU issue stage: valid/ready handshake and single-entry output register
// around the RV32I ALU decoder, with backpressure and flush.
module rv32_alu_issue_stage
  import rv32_alu_issue_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_ctrl,
  output logic [31:0] out_imm,
  output logic        out_use_imm,
  output logic        out_use_pc,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_illegal,
  output logic [31:0] out_pc
);

  decoded_t    dec_s;
  decoded_t    entry_r;
  logic        valid_r;
  logic [31:0] pc_r;
  logic        capture_s;

  rv32_alu_decoder u_decoder (
    .instr (in_instr),
    .dec   (dec_s)
  );

  assign in_ready  = !valid_r || out_ready;
  assign capture_s = in_valid && in_ready && !flush;

  // Entry register: flush wins, then capture (also covers consume+capture), then drain or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      entry_r <= '0;
      pc_r    <= RESET_PC;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (capture_s) begin
      valid_r <= 1'b1;
      entry_r <= dec_s;
      pc_r    <= in_pc;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid     = valid_r;
  assign out_alu_ctrl  = entry_r.alu_ctrl;
  assign out_imm       = entry_r.imm;
  assign out_use_imm   = entry_r.use_imm;
  assign out_use_pc    = entry_r.use_pc;
  assign out_rs1       = entry_r.rs1;
  assign out_rs2       = entry_r.rs2;
  assign out_rd        = entry_r.rd;
  assign out_reg_write = entry_r.reg_write;
  assign out_illegal   = entry_r.illegal;
  assign out_pc        = pc_r;

endmodule
